// File: rtl/qupls_prec_sequencer.sv
// Precision sequencer: runs one 64-bit ALU beat (two for hexi) per op and extends the result.
// Define QUPLS_PREC_SEQ_SIGNEXT_EN to sign-extend sub-hexi results (default zero-extends).
module qupls_prec_sequencer #(
  parameter int TAG_WID = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [2:0]         i_prec,
  input  logic [1:0]         i_op,
  input  logic [127:0]       i_a,
  input  logic [127:0]       i_b,
  input  logic [TAG_WID-1:0] i_tag,
  input  logic               i_flush,
  output logic               alu_valid,
  output logic [1:0]         alu_op,
  output logic [63:0]        alu_a,
  output logic [63:0]        alu_b,
  output logic               alu_cin,
  output logic               alu_hi,
  input  logic               alu_done,
  input  logic [63:0]        alu_res,
  input  logic               alu_cout,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [127:0]       o_res,
  output logic [TAG_WID-1:0] o_tag,
  output logic [2:0]         o_prec
);

`ifdef QUPLS_PREC_SEQ_SIGNEXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [2:0] P_HEXI = 3'd4;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t               state, state_n;
  logic [1:0]           op_q;
  logic [2:0]           prec_q;
  logic [127:0]         a_q, b_q;
  logic [TAG_WID-1:0]   tag_q;
  logic                 carry_q;
  logic [63:0]          res_lo, res_hi;
  logic [127:0]         ext;
  logic                 accept;
  logic                 lo_done, hi_done;

  assign accept  = i_valid & i_ready;
  assign lo_done = (state == LO) & alu_done & ~i_flush;
  assign hi_done = (state == HI) & alu_done & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = LO;
      LO: begin
        if (i_flush)       state_n = IDLE;
        else if (alu_done) state_n = (prec_q == P_HEXI) ? HI : DONE;
      end
      HI: begin
        if (i_flush)       state_n = IDLE;
        else if (alu_done) state_n = DONE;
      end
      DONE: if (i_flush || o_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      prec_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      carry_q <= 1'b0;
      res_lo  <= '0;
      res_hi  <= '0;
    end else begin
      if (accept) begin
        op_q   <= i_op;
        prec_q <= i_prec;
        a_q    <= i_a;
        b_q    <= i_b;
        tag_q  <= i_tag;
      end
      // logic ops never chain a carry into the high beat
      if (lo_done) begin
        res_lo  <= alu_res;
        carry_q <= alu_cout & ((op_q == OP_ADD) | (op_q == OP_SUB));
      end
      if (hi_done) res_hi <= alu_res;
    end
  end

  always_comb begin
    unique case (prec_q)
      3'd0:    ext = {{120{SEXT & res_lo[7]}}, res_lo[7:0]};
      3'd1:    ext = {{112{SEXT & res_lo[15]}}, res_lo[15:0]};
      3'd2:    ext = {{96{SEXT & res_lo[31]}}, res_lo[31:0]};
      3'd4:    ext = {res_hi, res_lo};
      default: ext = {{64{SEXT & res_lo[63]}}, res_lo};
    endcase
  end

  always_comb begin
    i_ready   = 1'b0;
    alu_valid = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    alu_hi    = 1'b0;
    o_valid   = 1'b0;
    o_res     = '0;
    o_tag     = '0;
    o_prec    = '0;
    unique case (state)
      IDLE: i_ready = rst_n & ~i_flush;
      LO: begin
        alu_valid = 1'b1;
        alu_op    = op_q;
        alu_a     = a_q[63:0];
        alu_b     = b_q[63:0];
        alu_cin   = (op_q == OP_SUB);
      end
      HI: begin
        alu_valid = 1'b1;
        alu_op    = op_q;
        alu_a     = a_q[127:64];
        alu_b     = b_q[127:64];
        alu_cin   = carry_q;
        alu_hi    = 1'b1;
      end
      DONE: begin
        o_valid = 1'b1;
        o_res   = ext;
        o_tag   = tag_q;
        o_prec  = prec_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qupls_prec_sequencer.sv
// Directed bench for qupls_prec_sequencer with a behavioural stallable 64-bit ALU.
// Expected sub-hexi extension follows QUPLS_PREC_SEQ_SIGNEXT_EN.
module tb_qupls_prec_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid, i_ready, i_flush;
  logic [2:0]   i_prec;
  logic [1:0]   i_op;
  logic [127:0] i_a, i_b;
  logic [4:0]   i_tag;
  logic         alu_valid, alu_cin, alu_hi, alu_done, alu_cout;
  logic [1:0]   alu_op;
  logic [63:0]  alu_a, alu_b, alu_res;
  logic         o_valid, o_ready;
  logic [127:0] o_res;
  logic [4:0]   o_tag;
  logic [2:0]   o_prec;
  logic         stall;
  logic [64:0]  sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qupls_prec_sequencer #(.TAG_WID(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_prec(i_prec), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_tag(i_tag), .i_flush(i_flush),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_hi(alu_hi), .alu_done(alu_done),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res),
    .o_tag(o_tag), .o_prec(o_prec)
  );

  // Reference ALU: sub computes a + ~b + cin
  always_comb begin
    sum      = {1'b0, alu_a} + {1'b0, (alu_op == 2'd1) ? ~alu_b : alu_b} + {64'd0, alu_cin};
    alu_cout = sum[64];
    unique case (alu_op)
      2'd2:    alu_res = alu_a & alu_b;
      2'd3:    alu_res = alu_a | alu_b;
      default: alu_res = sum[63:0];
    endcase
    alu_done = alu_valid & ~stall;
  end

  task automatic issue(input logic [2:0] p, input logic [1:0] op,
                       input logic [127:0] a, input logic [127:0] b,
                       input logic [4:0] tag);
    i_valid = 1'b1; i_prec = p; i_op = op; i_a = a; i_b = b; i_tag = tag;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({i_ready, alu_valid, o_valid} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl got %b exp 000", {i_ready, alu_valid, o_valid});
    end
    tests++;
    if ({o_res, o_tag, o_prec, alu_a, alu_cin, alu_hi} !== '0) begin
      fails++; $display("FAIL reset_data got o_res=%h o_tag=%h exp 0", o_res, o_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (i_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b exp 1", i_ready);
    end
  endtask

  task automatic test_octa_add;
    @(negedge clk);
    issue(3'd3, 2'd0, 128'd5, 128'd7, 5'd3);
    tests++;
    if ({alu_valid, alu_hi, alu_cin, o_valid} !== 4'b1000 || alu_a !== 64'd5 || alu_b !== 64'd7) begin
      fails++; $display("FAIL octa_lo_beat got v%b h%b c%b ov%b a=%h exp 1000 a=5",
                        alu_valid, alu_hi, alu_cin, o_valid, alu_a);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== 128'd12 || o_tag !== 5'd3 || o_prec !== 3'd3) begin
      fails++; $display("FAIL octa_add got v%b res=%h tag=%h exp 1 res=c tag=3", o_valid, o_res, o_tag);
    end
    @(negedge clk);
    tests++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++; $display("FAIL octa_release got rdy%b ov%b exp 1 0", i_ready, o_valid);
    end
  endtask

  task automatic test_hexi_add;
    @(negedge clk);
    issue(3'd4, 2'd0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 5'd4);
    tests++;
    if (alu_hi !== 1'b0 || alu_cin !== 1'b0 || alu_cout !== 1'b1) begin
      fails++; $display("FAIL hexi_lo got hi%b cin%b cout%b exp 0 0 1", alu_hi, alu_cin, alu_cout);
    end
    @(negedge clk);
    tests++;
    if ({alu_valid, alu_hi, alu_cin, o_valid} !== 4'b1110 || alu_a !== 64'd0) begin
      fails++; $display("FAIL hexi_hi got v%b h%b c%b ov%b exp 1110", alu_valid, alu_hi, alu_cin, o_valid);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== 128'h1_0000_0000_0000_0000 || o_prec !== 3'd4) begin
      fails++; $display("FAIL hexi_add got v%b res=%h exp 1 res=10000000000000000", o_valid, o_res);
    end
  endtask

  task automatic test_hexi_sub;
    @(negedge clk);
    issue(3'd4, 2'd1, {64'd1, 64'd0}, 128'd1, 5'd5);
    tests++;
    if (alu_cin !== 1'b1 || alu_cout !== 1'b0) begin
      fails++; $display("FAIL hsub_lo got cin%b cout%b exp 1 0", alu_cin, alu_cout);
    end
    @(negedge clk);
    tests++;
    if (alu_cin !== 1'b0 || alu_hi !== 1'b1) begin
      fails++; $display("FAIL hsub_hi got cin%b hi%b exp 0 1", alu_cin, alu_hi);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== {64'd0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      fails++; $display("FAIL hexi_sub got v%b res=%h exp 1 res=ffffffffffffffff", o_valid, o_res);
    end
  endtask

  task automatic test_narrow;
    logic [127:0] e_byt, e_tet;
`ifdef QUPLS_PREC_SEQ_SIGNEXT_EN
    e_byt = {{120{1'b1}}, 8'h80};
    e_tet = {128{1'b1}};
`else
    e_byt = 128'h80;
    e_tet = 128'hFFFF_FFFF;
`endif
    @(negedge clk);
    issue(3'd0, 2'd0, 128'h7F, 128'h01, 5'd6);
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== e_byt) begin
      fails++; $display("FAIL byt_add got v%b res=%h exp %h", o_valid, o_res, e_byt);
    end
    @(negedge clk);
    @(negedge clk);
    issue(3'd2, 2'd1, 128'd0, 128'd1, 5'd7);
    @(negedge clk);
    tests++;
    if (o_res !== e_tet) begin
      fails++; $display("FAIL tetra_sub got %h exp %h", o_res, e_tet);
    end
    @(negedge clk);
    @(negedge clk);
    issue(3'd6, 2'd2, 128'hF0F0, 128'hFF00, 5'd8);
    tests++;
    if (alu_cin !== 1'b0) begin
      fails++; $display("FAIL and_cin got %b exp 0", alu_cin);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== 128'hF000 || o_prec !== 3'd6) begin
      fails++; $display("FAIL prec6_and got v%b res=%h prec=%0d exp 1 f000 6", o_valid, o_res, o_prec);
    end
  endtask

  task automatic test_alu_wait;
    @(negedge clk);
    @(negedge clk);
    issue(3'd3, 2'd3, 128'd1, 128'd2, 5'd9);
    stall = 1'b1;
    @(negedge clk);
    tests++;
    if (alu_valid !== 1'b1 || alu_a !== 64'd1 || o_valid !== 1'b0) begin
      fails++; $display("FAIL wait_hold got v%b a=%h ov%b exp 1 1 0", alu_valid, alu_a, o_valid);
    end
    @(negedge clk);
    stall = 1'b0;
    tests++;
    if (o_valid !== 1'b0) begin
      fails++; $display("FAIL wait_early got ov%b exp 0", o_valid);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== 128'd3) begin
      fails++; $display("FAIL wait_done got v%b res=%h exp 1 3", o_valid, o_res);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    o_ready = 1'b0;
    issue(3'd3, 2'd3, 128'h12, 128'h21, 5'd9);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (o_valid !== 1'b1 || o_res !== 128'h33 || o_tag !== 5'd9 || i_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold%0d got v%b res=%h tag=%h rdy%b exp 1 33 9 0",
                          k, o_valid, o_res, o_tag, i_ready);
      end
      @(negedge clk);
    end
    o_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release got rdy%b ov%b exp 1 0", i_ready, o_valid);
    end
  endtask

  task automatic test_flush;
    issue(3'd4, 2'd0, {64'd9, 64'd9}, {64'd1, 64'd1}, 5'd10);
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    #1;
    tests++;
    if (o_valid !== 1'b0 || alu_valid !== 1'b0 || i_ready !== 1'b1) begin
      fails++; $display("FAIL flush_hi got ov%b av%b rdy%b exp 0 0 1", o_valid, alu_valid, i_ready);
    end
    i_flush = 1'b1;
    #1;
    tests++;
    if (i_ready !== 1'b0) begin
      fails++; $display("FAIL flush_idle got rdy%b exp 0", i_ready);
    end
    i_flush = 1'b0;
    @(negedge clk);
    issue(3'd3, 2'd0, 128'd100, 128'd23, 5'd11);
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== 128'd123 || o_tag !== 5'd11) begin
      fails++; $display("FAIL flush_next got v%b res=%h tag=%h exp 1 7b b", o_valid, o_res, o_tag);
    end
  endtask

  task automatic test_reset_in_hi;
    @(negedge clk);
    issue(3'd4, 2'd0, 128'd1, 128'd1, 5'd12);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    tests++;
    if (alu_valid !== 1'b1 || alu_hi !== 1'b1) begin
      fails++; $display("FAIL stall_hi got av%b hi%b exp 1 1", alu_valid, alu_hi);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (alu_valid !== 1'b0 || o_valid !== 1'b0 || i_ready !== 1'b0 || alu_hi !== 1'b0) begin
      fails++; $display("FAIL rst_hi got av%b ov%b rdy%b exp 0 0 0", alu_valid, o_valid, i_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    issue(3'd3, 2'd1, 128'd50, 128'd8, 5'd13);
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1 || o_res !== 128'd42 || o_tag !== 5'd13) begin
      fails++; $display("FAIL rst_next got v%b res=%h tag=%h exp 1 2a d", o_valid, o_res, o_tag);
    end
  endtask

  initial begin
    i_valid = 1'b0; i_flush = 1'b0; i_prec = '0; i_op = '0;
    i_a = '0; i_b = '0; i_tag = '0; o_ready = 1'b1; stall = 1'b0;
    test_reset();
    test_octa_add();
    test_hexi_add();
    test_hexi_sub();
    test_narrow();
    test_alu_wait();
    test_backpressure();
    test_flush();
    test_reset_in_hi();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
